// File: rtl/axi_inf_write_burst_engine.sv
// axi_inf_write_burst_engine
// Splits one write request of req_len beats into AXI4 INCR bursts of at most
// MAX_BURST beats, keeps up to OUTSTANDING bursts in flight, drives WLAST from
// a queue of issued burst lengths and reports completion once every B is back.
// Build option: define AXI_4K_SPLIT_EN to stop bursts crossing a 4 KB page.
//
// state | meaning
// IDLE  | waiting for write_req
// CALC  | size the next burst from remaining beats and current address
// AW    | present AW until handshake (held off while outstanding is full)
// DRAIN | every AW issued; wait for outstanding W and B traffic to finish
// DONE  | report completion and the sticky error

module axi_inf_write_burst_engine #(
    parameter int IDSIZE      = 3,
    parameter int ID          = 0,
    parameter int ASIZE       = 32,
    parameter int DSIZE       = 256,
    parameter int TLSIZE      = 16,
    parameter int MAX_BURST   = 16,
    parameter int OUTSTANDING = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic              write_req,
    input  logic [ASIZE-1:0]  req_addr,
    input  logic [TLSIZE-1:0] req_len,
    output logic              req_resp,
    output logic              req_done,
    output logic              req_err,
    output logic              busy,
    output logic              pull_data_en,
    output logic [IDSIZE-1:0] axi_awid,
    output logic [ASIZE-1:0]  axi_awaddr,
    output logic [7:0]        axi_awlen,
    output logic [2:0]        axi_awsize,
    output logic [1:0]        axi_awburst,
    output logic              axi_awlock,
    output logic [3:0]        axi_awcache,
    output logic [2:0]        axi_awprot,
    output logic [3:0]        axi_awqos,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    input  logic              axi_wvalid,
    input  logic              axi_wready,
    output logic              axi_wlast,
    input  logic [IDSIZE-1:0] axi_bid,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready
);

    localparam int BPB_LOG = $clog2(DSIZE / 8);
    localparam int OCW     = $clog2(OUTSTANDING) + 1;
    localparam int QAW     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int QDEPTH  = 1 << QAW;
    localparam int CW      = (TLSIZE > 13) ? TLSIZE : 13;

    typedef enum logic [2:0] {IDLE, CALC, AW, DRAIN, DONE} state_t;

    state_t            state;
    logic [ASIZE-1:0]  addr_r;
    logic [TLSIZE-1:0] rem_r;
    logic [8:0]        blen_r;
    logic [8:0]        blen_c;
    logic [OCW-1:0]    out_cnt, out_nx;
    logic              err_sticky;
    logic [8:0]        q_mem [QDEPTH];
    logic [QAW-1:0]    q_wr, q_rd;
    logic [OCW-1:0]    q_cnt, q_cnt_nx;
    logic [8:0]        beat_cnt, beat_nx, head, head_nx;
    logic              w_last_beat, wlast_nx;
    logic              aw_fire, b_fire, w_fire, can_issue;
    logic [CW-1:0]     rem_w, lim_w;
`ifdef AXI_4K_SPLIT_EN
    logic [CW-1:0]     k4_w;
`endif

    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awqos   = 4'd0;

    assign aw_fire   = axi_awvalid & axi_awready;
    assign b_fire    = axi_bvalid & axi_bready & (axi_bid == IDSIZE'(ID));
    assign w_fire    = axi_wvalid & axi_wready & (q_cnt != '0);
    // The queue check only matters if a B ever overtakes its W data.
    assign can_issue = (out_cnt < OCW'(OUTSTANDING)) & (q_cnt < OCW'(OUTSTANDING));

    // Next burst length: remaining beats capped by MAX_BURST (and the 4 KB page).
    always_comb begin
        rem_w = CW'(rem_r);
        lim_w = CW'(MAX_BURST);
        if (rem_w < lim_w) lim_w = rem_w;
`ifdef AXI_4K_SPLIT_EN
        k4_w = CW'((13'h1000 - {1'b0, addr_r[11:0]}) >> BPB_LOG);
        if (k4_w < lim_w) lim_w = k4_w;
`endif
        blen_c = 9'(lim_w);
    end

    // Request sequencing and AW channel.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state       <= IDLE;
            addr_r      <= '0;
            rem_r       <= '0;
            blen_r      <= '0;
            axi_awid    <= '0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
            axi_awvalid <= 1'b0;
            req_resp    <= 1'b0;
            req_done    <= 1'b0;
            req_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_resp <= 1'b0;
            req_done <= 1'b0;
            req_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_req) begin
                        req_resp <= 1'b1;
                        busy     <= 1'b1;
                        addr_r   <= req_addr;
                        rem_r    <= req_len;
                        state    <= (req_len != '0) ? CALC : DONE;
                    end
                end
                CALC: begin
                    blen_r      <= blen_c;
                    axi_awaddr  <= addr_r;
                    axi_awlen   <= 8'(blen_c - 9'd1);
                    axi_awid    <= IDSIZE'(ID);
                    axi_awsize  <= 3'(BPB_LOG);
                    axi_awburst <= 2'b01;
                    axi_awvalid <= can_issue;
                    state       <= AW;
                end
                AW: begin
                    if (axi_awvalid && axi_awready) begin
                        axi_awvalid <= 1'b0;
                        addr_r      <= addr_r + (ASIZE'(blen_r) << BPB_LOG);
                        rem_r       <= rem_r - TLSIZE'(blen_r);
                        state       <= (rem_r == TLSIZE'(blen_r)) ? DRAIN : CALC;
                    end else if (!axi_awvalid && can_issue) begin
                        axi_awvalid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_cnt == '0 && q_cnt == '0) state <= DONE;
                end
                DONE: begin
                    req_done <= 1'b1;
                    req_err  <= err_sticky;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding count: simultaneous AW and B handshakes cancel.
    always_comb begin
        out_nx = out_cnt;
        if (aw_fire && !b_fire) out_nx = out_cnt + OCW'(1);
        else if (!aw_fire && b_fire) out_nx = out_cnt - OCW'(1);
    end

    // B channel: outstanding counter, bready and sticky error.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            out_cnt    <= '0;
            axi_bready <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_cnt    <= out_nx;
            axi_bready <= (out_nx != '0);
            if (state == IDLE && write_req) err_sticky <= 1'b0;
            else if (b_fire && axi_bresp != 2'b00) err_sticky <= 1'b1;
        end
    end

    // Next W-path state; wlast is precomputed so it can leave a flop.
    always_comb begin
        head        = q_mem[q_rd];
        w_last_beat = w_fire && (beat_cnt == head - 9'd1);
        q_cnt_nx    = q_cnt;
        if (aw_fire && !w_last_beat) q_cnt_nx = q_cnt + OCW'(1);
        else if (!aw_fire && w_last_beat) q_cnt_nx = q_cnt - OCW'(1);
        if (w_last_beat) beat_nx = 9'd0;
        else if (w_fire) beat_nx = beat_cnt + 9'd1;
        else beat_nx = beat_cnt;
        // A length pushed this cycle becomes the head if the queue would otherwise empty.
        if (w_last_beat) head_nx = (q_cnt == OCW'(1)) ? blen_r : q_mem[q_rd + QAW'(1)];
        else head_nx = (q_cnt == '0) ? blen_r : head;
        wlast_nx = (q_cnt_nx != '0) && (beat_nx == head_nx - 9'd1);
    end

    // Length queue pointers, beat counter and registered W outputs.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            q_wr         <= '0;
            q_rd         <= '0;
            q_cnt        <= '0;
            beat_cnt     <= '0;
            axi_wlast    <= 1'b0;
            pull_data_en <= 1'b0;
        end else begin
            if (aw_fire) q_wr <= q_wr + QAW'(1);
            if (w_last_beat) q_rd <= q_rd + QAW'(1);
            q_cnt        <= q_cnt_nx;
            beat_cnt     <= beat_nx;
            axi_wlast    <= wlast_nx;
            pull_data_en <= (q_cnt_nx != '0);
        end
    end

    // Length queue storage; validity is tracked by the pointers alone.
    always_ff @(posedge axi_aclk) begin
        if (aw_fire) q_mem[q_wr] <= blen_r;
    end

endmodule

// File: tb/tb_axi_inf_write_burst_engine.sv
// Bench for axi_inf_write_burst_engine: expected bursts are pushed to
// scoreboard queues when a request is issued and popped on AW/W handshakes.
module tb_axi_inf_write_burst_engine;

    localparam int OUTS = 2;
    localparam int BPB  = 32;
    localparam int MAXB = 16;

    logic        axi_aclk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        write_req = 1'b0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        req_resp, req_done, req_err, busy, pull_data_en;
    logic [2:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_awqos;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready = 1'b0;
    logic        axi_wlast;
    logic [2:0]  axi_bid = '0;
    logic [1:0]  axi_bresp = '0;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;

    always #5 axi_aclk = ~axi_aclk;

    axi_inf_write_burst_engine #(.OUTSTANDING(OUTS)) dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset), .write_req(write_req),
        .req_addr(req_addr), .req_len(req_len), .req_resp(req_resp),
        .req_done(req_done), .req_err(req_err), .busy(busy),
        .pull_data_en(pull_data_en), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );

    wire [67:0] all_outs = {req_resp, req_done, req_err, busy, pull_data_en, axi_awid,
                            axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
                            axi_awcache, axi_awprot, axi_awqos, axi_awvalid, axi_wlast,
                            axi_bready};

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    burst_t exp_aw_q[$];
    int     exp_w_q[$];
    burst_t mon_e;
    int     beat = 0, b_pending = 0, out_model = 0, n_aw = 0, n_b_req = 0;
    int     err_b_idx = 0, nb_exp = 0, last_len = 0;
    bit     b_en = 1'b1, rnd = 1'b0, bogus_pending = 1'b0, b_drop = 1'b0, b_is_bogus = 1'b0;

    // Responder and monitor: inputs are set at negedge, then the handshakes
    // that will happen at the next posedge are scored.
    always @(negedge axi_aclk) begin
        if (axi_reset) begin
            exp_aw_q.delete();
            exp_w_q.delete();
            beat = 0; b_pending = 0; out_model = 0;
            b_drop = 1'b0; bogus_pending = 1'b0;
            axi_bvalid = 1'b0; axi_awready = 1'b0; axi_wvalid = 1'b0; axi_wready = 1'b0;
        end else begin
            check_val("bready", axi_bready, out_model != 0);
            if (out_model == OUTS) check_val("aw_gate", axi_awvalid, 0);
            axi_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi_wready  = 1'b1;
            axi_wvalid  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (b_drop) begin
                axi_bvalid = 1'b0;
                b_drop = 1'b0;
            end
            if (!axi_bvalid) begin
                if (bogus_pending && axi_bready) begin
                    axi_bvalid = 1'b1; axi_bid = 3'd1; axi_bresp = 2'b10; b_is_bogus = 1'b1;
                end else if (b_pending > 0 && b_en && (!rnd || $urandom_range(0, 1) == 1)) begin
                    axi_bvalid = 1'b1; axi_bid = 3'd0; b_is_bogus = 1'b0;
                    axi_bresp = (n_b_req + 1 == err_b_idx) ? 2'b10 : 2'b00;
                end
            end
            if (axi_awvalid && axi_awready) begin
                check_val("aw_unexp", exp_aw_q.size() != 0, 1);
                if (exp_aw_q.size() != 0) begin
                    mon_e = exp_aw_q.pop_front();
                    check_val("awaddr", axi_awaddr, mon_e.addr);
                    check_val("awlen", axi_awlen, 64'(mon_e.len - 1));
                    check_val("awsize", axi_awsize, 5);
                    check_val("awburst", axi_awburst, 1);
                    check_val("awid", axi_awid, 0);
                end
                n_aw++;
                out_model++;
            end
            if (axi_wvalid && axi_wready && pull_data_en) begin
                check_val("w_unexp", exp_w_q.size() != 0, 1);
                if (exp_w_q.size() != 0) begin
                    beat++;
                    check_val("wlast", axi_wlast, beat == exp_w_q[0]);
                    if (beat == exp_w_q[0]) begin
                        void'(exp_w_q.pop_front());
                        beat = 0;
                        b_pending++;
                    end
                end
            end
            if (axi_bvalid && axi_bready) begin
                b_drop = 1'b1;
                if (b_is_bogus) bogus_pending = 1'b0;
                else begin
                    b_pending--;
                    n_b_req++;
                    out_model--;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge axi_aclk);
        #2;
    endtask

    task automatic start_req(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int r, b, lim;
        a = addr; r = len; nb_exp = 0;
        while (r > 0) begin
            b = (r < MAXB) ? r : MAXB;
`ifdef AXI_4K_SPLIT_EN
            lim = (4096 - int'(a & 32'hFFF)) / BPB;
            if (lim < b) b = lim;
`else
            lim = 0;
`endif
            exp_aw_q.push_back('{a, b});
            exp_w_q.push_back(b);
            a = a + 32'(b * BPB);
            r = r - b;
            nb_exp++;
        end
        n_b_req = 0; n_aw = 0; last_len = len;
        cyc();
        write_req = 1'b1; req_addr = addr; req_len = 16'(len);
        cyc();
        write_req = 1'b0;
        check_val("req_resp", req_resp, 1);
        check_val("busy_on", busy, 1);
    endtask

    task automatic finish_req(input bit exp_err);
        int n;
        n = 0;
        while (!req_done && n < 3000) begin
            cyc();
            n++;
        end
        check_val("done_seen", req_done, 1);
        check_val("req_err", req_err, exp_err);
        check_val("b_count", n_b_req, nb_exp);
        check_val("aw_left", exp_aw_q.size(), 0);
        check_val("w_left", exp_w_q.size(), 0);
        if (last_len == 0) check_val("zero_lat", n, 1);
        cyc();
        check_val("done_pulse", req_done, 0);
        check_val("busy_off", busy, 0);
    endtask

    task automatic run_req(input logic [31:0] addr, input int len, input bit exp_err);
        start_req(addr, len);
        finish_req(exp_err);
    endtask

    initial begin
        repeat (3) cyc();
        check_val("rst_outs", |all_outs, 0);
        axi_reset = 1'b0;
        repeat (2) cyc();

        run_req(32'h0, 40, 0);
        run_req(32'hF80, 16, 0);
        run_req(32'hFFFF_FF00, 20, 0);

        // outstanding limit with B held off, plus a request while busy
        b_en = 1'b0;
        start_req(32'h2000, 64);
        repeat (60) cyc();
        check_val("aw_held_cnt", n_aw, 2);
        check_val("aw_held_valid", axi_awvalid, 0);
        write_req = 1'b1; req_len = 16'd5;
        cyc();
        write_req = 1'b0;
        check_val("busy_req_ign", req_resp, 0);
        b_en = 1'b1;
        finish_req(0);
        check_val("aw_total", n_aw, 4);

        // error response with a foreign-ID B slipped in first
        bogus_pending = 1'b1;
        err_b_idx = 2;
        run_req(32'h3000, 40, 1);
        err_b_idx = 0;
        run_req(32'h4000, 16, 0);

        run_req(32'h5000, 1, 0);
        run_req(32'h6000, 0, 0);

        rnd = 1'b1;
        run_req(32'h7020, 37, 0);
        rnd = 1'b0;

        // reset with two bursts in flight
        b_en = 1'b0;
        start_req(32'h8000, 64);
        for (int i = 0; i < 200 && n_aw < 2; i++) cyc();
        check_val("rst_aw_cnt", n_aw, 2);
        axi_reset = 1'b1;
        #1;
        check_val("midrst_outs", |all_outs, 0);
        repeat (2) cyc();
        axi_reset = 1'b0;
        b_en = 1'b1;
        cyc();
        run_req(32'h9000, 16, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
